// File: rtl/bcd_disp_scan_pkg.sv
// Shared constants and helpers for multiplexed 7-segment displays.
// Segment codes are active-low, ordered g..a as [6:0].
package bcd_disp_scan_pkg;

    localparam int NUM_DIGITS = 5;
    localparam int IDX_W      = 3;

    typedef logic [3:0]       bcd_t;
    typedef logic [6:0]       seg_t;
    typedef logic [IDX_W-1:0] idx_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam idx_t IDX_FIRST = 3'd0;
    localparam idx_t IDX_LAST  = 3'd4;

    function automatic bcd_t digit_of(
        input logic [4*NUM_DIGITS-1:0] v,
        input idx_t                    k
    );
        bcd_t d;
        d = v[3:0];
        case (k)
            3'd1:    d = v[7:4];
            3'd2:    d = v[11:8];
            3'd3:    d = v[15:12];
            3'd4:    d = v[19:16];
            default: d = v[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment code; non-BCD values show 'E'.
module seg7_decode
    import bcd_disp_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// Five-digit BCD multiplexed display scanner with frame-synchronous
// value capture, hold, leading-zero blanking and decimal points.
module bcd_disp_scan
    import bcd_disp_scan_pkg::*;
#(
    parameter int freq_p    = 50000000,
    parameter int scan_hz_p = 1000
) (
    input  logic        clk_i,
    input  logic        nReset_i,
    input  logic [19:0] count_i,
    input  logic        hold_i,
    input  logic        blank_lz_i,
    input  logic [4:0]  dp_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [4:0]  an_o,
    output logic        frame_o
);

    localparam int DIV = freq_p / scan_hz_p;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          tick_q;
    logic          frame_start;
    idx_t          idx;
    logic [19:0]   snap;

    bcd_t          cur_digit;
    seg_t          dec_seg;
    logic [4:0]    zero_from;
    logic          blank_cur;

    assign tick        = (presc == TERM);
    assign frame_start = tick && (idx == IDX_LAST);

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            idx     <= IDX_LAST;
            snap    <= '0;
            frame_o <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            frame_o <= frame_start;
            tick_q  <= tick;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? IDX_FIRST : idx + 3'd1;
            end
            if (frame_start && !hold_i) begin
                snap <= count_i;
            end
        end
    end

    // zero_from[k]: snap digits k..4 are all zero
    always_comb begin
        zero_from[4] = (snap[19:16] == 4'd0);
        zero_from[3] = zero_from[4] && (snap[15:12] == 4'd0);
        zero_from[2] = zero_from[3] && (snap[11:8] == 4'd0);
        zero_from[1] = zero_from[2] && (snap[7:4] == 4'd0);
        zero_from[0] = zero_from[1] && (snap[3:0] == 4'd0);
    end

    assign cur_digit = digit_of(snap, idx);
    assign blank_cur = blank_lz_i
                    && (idx != IDX_FIRST)
                    && zero_from[idx];

    seg7_decode u_dec (
        .nibble_i (cur_digit),
        .seg_o    (dec_seg)
    );

    // Outputs follow the tick by one cycle so idx/snap are already updated.
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            an_o  <= 5'b11111;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end else if (tick_q) begin
            an_o  <= ~(5'b00001 << idx);
            seg_o <= blank_cur ? SEG_BLANK : dec_seg;
            dp_o  <= ~dp_i[idx];
        end
    end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Directed self-checking bench for bcd_disp_scan.
// Scan runs at 100 Hz clock / 10 Hz digit rate: one digit per 10 cycles.
module tb_bcd_disp_scan;

    logic        clk_i;
    logic        nReset_i;
    logic [19:0] count_i;
    logic        hold_i;
    logic        blank_lz_i;
    logic [4:0]  dp_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [4:0]  an_o;
    logic        frame_o;

    int checks;
    int errors;

    logic [4:0] cap_an  [5];
    logic [6:0] cap_seg [5];
    logic       cap_dp  [5];
    logic       cap_frame_after;

    logic [4:0] an_exp [5];

    bcd_disp_scan #(
        .freq_p    (100),
        .scan_hz_p (10)
    ) dut (
        .clk_i      (clk_i),
        .nReset_i   (nReset_i),
        .count_i    (count_i),
        .hold_i     (hold_i),
        .blank_lz_i (blank_lz_i),
        .dp_i       (dp_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Waits for frame_o, then records each digit's outputs of that frame.
    task automatic capture_frame(output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (frame_o !== 1'b1 && n < 80) begin
            @(negedge clk_i);
            n++;
        end
        if (frame_o !== 1'b1) return;
        ok = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cap_frame_after = frame_o;
        for (int k = 0; k < 5; k++) begin
            cap_an[k]  = an_o;
            cap_seg[k] = seg_o;
            cap_dp[k]  = dp_o;
            if (k < 4) repeat (10) @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        nReset_i   = 1'b0;
        count_i    = 20'h12345;
        hold_i     = 1'b0;
        blank_lz_i = 1'b0;
        dp_i       = 5'b00000;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {5'b11111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b frame=%b, want an=11111 seg=1111111 dp=1 frame=0",
                     an_o, seg_o, dp_o, frame_o);
        end
    endtask

    task automatic test_basic_scan();
        logic ok;
        logic [6:0] exp_seg [5];
        exp_seg[0] = 7'b0010010;
        exp_seg[1] = 7'b0011001;
        exp_seg[2] = 7'b0110000;
        exp_seg[3] = 7'b0100100;
        exp_seg[4] = 7'b1111001;
        nReset_i = 1'b1;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_frame_timeout: got no frame_o, want pulse");
            return;
        end
        checks++;
        if (cap_frame_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame_width: got frame_o=%b after pulse, want 0", cap_frame_after);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cap_an[k] !== an_exp[k] || cap_seg[k] !== exp_seg[k]) begin
                errors++;
                $display("FAIL basic_digit%0d: got an=%b seg=%b, want an=%b seg=%b",
                         k, cap_an[k], cap_seg[k], an_exp[k], exp_seg[k]);
            end
        end
    endtask

    task automatic test_blanking();
        logic ok;
        logic [6:0] exp_on  [5];
        logic [6:0] exp_off [5];
        exp_on[0]  = 7'b1000000;
        exp_on[1]  = 7'b1111000;
        exp_on[2]  = 7'b1111111;
        exp_on[3]  = 7'b1111111;
        exp_on[4]  = 7'b1111111;
        exp_off[0] = 7'b1000000;
        exp_off[1] = 7'b1111000;
        exp_off[2] = 7'b1000000;
        exp_off[3] = 7'b1000000;
        exp_off[4] = 7'b1000000;
        count_i    = 20'h00070;
        blank_lz_i = 1'b1;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL blank_on_timeout: got no frame_o, want pulse");
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cap_seg[k] !== exp_on[k] || cap_an[k] !== an_exp[k]) begin
                errors++;
                $display("FAIL blank_on_digit%0d: got an=%b seg=%b, want an=%b seg=%b",
                         k, cap_an[k], cap_seg[k], an_exp[k], exp_on[k]);
            end
        end
        blank_lz_i = 1'b0;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL blank_off_timeout: got no frame_o, want pulse");
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cap_seg[k] !== exp_off[k]) begin
                errors++;
                $display("FAIL blank_off_digit%0d: got seg=%b, want seg=%b",
                         k, cap_seg[k], exp_off[k]);
            end
        end
    endtask

    task automatic test_hold();
        logic ok;
        count_i = 20'h11111;
        hold_i  = 1'b0;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_load_timeout: got no frame_o, want pulse");
            return;
        end
        // Change while digit 4 of the frame is still being shown
        hold_i  = 1'b1;
        count_i = 20'h22222;
        for (int f = 0; f < 3; f++) begin
            capture_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL hold_frame%0d_timeout: got no frame_o, want pulse", f);
                return;
            end
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (cap_seg[k] !== 7'b1111001) begin
                    errors++;
                    $display("FAIL hold_f%0d_digit%0d: got seg=%b, want seg=1111001",
                             f, k, cap_seg[k]);
                end
            end
        end
        hold_i = 1'b0;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_release_timeout: got no frame_o, want pulse");
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cap_seg[k] !== 7'b0100100) begin
                errors++;
                $display("FAIL hold_release_digit%0d: got seg=%b, want seg=0100100",
                         k, cap_seg[k]);
            end
        end
    endtask

    task automatic test_non_bcd();
        logic ok;
        count_i    = 20'hA000F;
        blank_lz_i = 1'b0;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nonbcd_timeout: got no frame_o, want pulse");
            return;
        end
        checks++;
        if (cap_seg[0] !== 7'b0000110 || cap_seg[4] !== 7'b0000110) begin
            errors++;
            $display("FAIL nonbcd_e: got d0=%b d4=%b, want 0000110 both",
                     cap_seg[0], cap_seg[4]);
        end
        checks++;
        if (cap_seg[1] !== 7'b1000000) begin
            errors++;
            $display("FAIL nonbcd_d1: got seg=%b, want seg=1000000", cap_seg[1]);
        end
        blank_lz_i = 1'b1;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nonbcd_blank_timeout: got no frame_o, want pulse");
            return;
        end
        checks++;
        if (cap_seg[0] !== 7'b0000110 || cap_seg[1] !== 7'b1000000) begin
            errors++;
            $display("FAIL nonbcd_blank: got d0=%b d1=%b, want d0=0000110 d1=1000000",
                     cap_seg[0], cap_seg[1]);
        end
        blank_lz_i = 1'b0;
    endtask

    task automatic test_dp();
        logic ok;
        count_i = 20'h12345;
        dp_i    = 5'b00100;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dp_timeout: got no frame_o, want pulse");
            return;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cap_dp[k] !== (k == 2 ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL dp_digit%0d: got dp=%b an=%b, want dp=%b",
                         k, cap_dp[k], cap_an[k], (k == 2 ? 1'b0 : 1'b1));
            end
        end
        dp_i = 5'b00000;
    endtask

    task automatic test_mid_reset();
        logic ok;
        int n;
        n = 0;
        while (frame_o !== 1'b1 && n < 80) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (frame_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_sync_timeout: got no frame_o, want pulse");
            return;
        end
        @(posedge clk_i);
        repeat (21) @(negedge clk_i);
        checks++;
        if (an_o !== 5'b11011) begin
            errors++;
            $display("FAIL midrst_precond: got an=%b, want an=11011", an_o);
        end
        nReset_i = 1'b0;
        #1;
        checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {5'b11111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrst_outputs: got an=%b seg=%b dp=%b frame=%b, want an=11111 seg=1111111 dp=1 frame=0",
                     an_o, seg_o, dp_o, frame_o);
        end
        count_i = 20'h98765;
        @(negedge clk_i);
        nReset_i = 1'b1;
        capture_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_frame_timeout: got no frame_o, want pulse");
            return;
        end
        checks++;
        if (cap_an[0] !== 5'b11110 || cap_seg[0] !== 7'b0010010) begin
            errors++;
            $display("FAIL midrst_digit0: got an=%b seg=%b, want an=11110 seg=0010010",
                     cap_an[0], cap_seg[0]);
        end
        checks++;
        if (cap_an[4] !== 5'b01111 || cap_seg[4] !== 7'b0010000) begin
            errors++;
            $display("FAIL midrst_digit4: got an=%b seg=%b, want an=01111 seg=0010000",
                     cap_an[4], cap_seg[4]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        an_exp[0] = 5'b11110;
        an_exp[1] = 5'b11101;
        an_exp[2] = 5'b11011;
        an_exp[3] = 5'b10111;
        an_exp[4] = 5'b01111;
        test_reset();
        test_basic_scan();
        test_blanking();
        test_hold();
        test_non_bcd();
        test_dp();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
